// File: rtl/ysyx_22040759_pc_fetch_ctrl.sv
// ysyx_22040759_pc_fetch_ctrl
// Holds the architectural PC and fetches one instruction at a time over a
// valid/ready instruction bus. It captures the returned word for decode and
// loads the next PC (computed upstream) when the instruction commits.
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   imem_req_valid/ready/addr      fetch request channel (addr is always pc)
//   imem_rsp_valid/data            fetch response channel
//   inst_valid, inst, inst_pc      captured instruction presented to decode
//   commit_valid, pc_new           retire strobe and next PC from select logic
//   pc                             architectural PC
//   misalign_err                   sticky: a committed pc_new had pc_new[1:0] != 0
//   fetch_timeout                  sticky: a fetch got no response in time
//
// Optional feature macro: YSYX_22040759_FETCH_TIMEOUT_EN
//   Defined   -> WAIT gives up after TIMEOUT_CYC cycles, sets fetch_timeout
//                and reissues the fetch at the same pc.
//   Undefined -> WAIT lasts indefinitely, fetch_timeout is tied low.
//
// state | meaning
// ------+-----------------------------------------------------------
// REQ   | request valid, waiting for memory to accept it
// WAIT  | request accepted, waiting for response data
// EXEC  | instruction held for decode, waiting for commit
module ysyx_22040759_pc_fetch_ctrl #(
   parameter logic [31:0] RESET_PC    = 32'h8000_0000,
   parameter int          TIMEOUT_CYC = 256
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        commit_valid,
   input  logic [31:0] pc_new,
   output logic [31:0] pc,
   output logic        misalign_err,
   output logic        fetch_timeout
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_EXEC = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   capture;
   logic   commit;
   logic   expire;

`ifdef YSYX_22040759_FETCH_TIMEOUT_EN
   localparam int            CW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

   logic [CW-1:0] wait_cnt;
   logic          timeout_q;

   // A response in the expiry cycle wins, so expiry requires no response.
   assign expire = (state == ST_WAIT) && !imem_rsp_valid && (wait_cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == ST_REQ && imem_req_ready) begin
            wait_cnt <= '0;
         end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (expire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign fetch_timeout = timeout_q;
`else
   assign expire        = 1'b0;
   assign fetch_timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_REQ;
      end else begin
         state <= state_nxt;
      end
   end

   // Outputs decode from state only, so they are valid during reset too.
   always_comb begin
      state_nxt      = ST_REQ;
      imem_req_valid = 1'b0;
      inst_valid     = 1'b0;
      capture        = 1'b0;
      commit         = 1'b0;
      case (state)
         ST_REQ: begin
            imem_req_valid = 1'b1;
            state_nxt      = imem_req_ready ? ST_WAIT : ST_REQ;
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               capture   = 1'b1;
               state_nxt = ST_EXEC;
            end else if (expire) begin
               state_nxt = ST_REQ;
            end else begin
               state_nxt = ST_WAIT;
            end
         end
         ST_EXEC: begin
            inst_valid = 1'b1;
            if (commit_valid) begin
               commit    = 1'b1;
               state_nxt = ST_REQ;
            end else begin
               state_nxt = ST_EXEC;
            end
         end
         default: state_nxt = ST_REQ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc           <= RESET_PC;
         inst         <= '0;
         inst_pc      <= '0;
         misalign_err <= 1'b0;
      end else begin
         if (capture) begin
            inst    <= imem_rsp_data;
            inst_pc <= pc;
         end
         if (commit) begin
            pc <= pc_new;
            if (pc_new[1:0] != 2'b00) begin
               misalign_err <= 1'b1;
            end
         end
      end
   end

   assign imem_req_addr = pc;

endmodule
